board_io_core: RTL and testbench

//  Single-clock board I/O front end for the test board. Generates rate ticks from clk_50mhz,

---
 rtl/board_io_pkg.sv | 24 ++
 rtl/board_io_tick_gen.sv | 39 +++
 rtl/board_io_core.sv | 129 ++++++++++++
 tb/tb_board_io_core.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// ----------------------------------------------------------------------------
// board_io_pkg
// Shared constants for the board I/O front end: display/key counts, debounce
// history depth, the common-anode 7-segment hex font and the tick divisor
// helper used by every rate generator.
// ----------------------------------------------------------------------------
package board_io_pkg;

    localparam int NUM_DIGITS     = 6;
    localparam int NUM_KEYS       = 8;
    localparam int DEBOUNCE_DEPTH = 3;

    // Active-low segments, bit0..6 = a..g, bit7 = dp (kept dark).
    localparam logic [7:0] SEG_FONT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Number of clk cycles between two ticks of the given rate.
    function automatic int divisor(input int clk_hz, input int rate);
        return clk_hz / rate;
    endfunction

endpackage

// File: rtl/board_io_tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
// Free-running divider producing a one-cycle clock enable at RATE Hz.
// Ports:
//   clk_50mhz  in   system clock
//   rst_       in   synchronous active-low reset
//   tick       out  high for one clk when the counter reaches N-1
// ----------------------------------------------------------------------------
module tick_gen
    import board_io_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int RATE   = 1
) (
    input  logic clk_50mhz,
    input  logic rst_,
    output logic tick
);

    localparam int N = divisor(CLK_HZ, RATE);
    localparam int W = (N > 2) ? $clog2(N) : 1;

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == W'(N - 1));
    assign tick   = w_last;

    always_ff @(posedge clk_50mhz) begin
        if (!rst_) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/board_io_core.sv
// ----------------------------------------------------------------------------
// board_io_core
// Board I/O front end: rate ticks, eight-key debouncer and a 6-digit
// multiplexed common-anode 7-segment driver, all on a single clock.
// Ports:
//   clk_50mhz  in   system clock (only clock)
//   rst_       in   synchronous active-low reset
//   key        in   raw pushbuttons, active-low, asynchronous
//   bcd_data   in   24-bit value, nibble i shown on digit i
//   key_level  out  debounced key state, active-high
//   key_rise   out  one-clk pulse on a debounced press
//   tick_sec   out  one-clk pulse at SEC_HZ
//   seg_data   out  active-low segments, dp always off
//   seg_cs     out  active-low one-hot digit select
// ----------------------------------------------------------------------------
module board_io_core
    import board_io_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int SCAN_HZ = 517,
    parameter int KEY_HZ  = 142,
    parameter int SEC_HZ  = 1
) (
    input  logic                  clk_50mhz,
    input  logic                  rst_,
    input  logic [NUM_KEYS-1:0]   key,
    input  logic [23:0]           bcd_data,
    output logic [NUM_KEYS-1:0]   key_level,
    output logic [NUM_KEYS-1:0]   key_rise,
    output logic                  tick_sec,
    output logic [7:0]            seg_data,
    output logic [NUM_DIGITS-1:0] seg_cs
);

    logic w_tick_scan;
    logic w_tick_key;
    logic w_tick_sec;

    tick_gen #(.CLK_HZ(CLK_HZ), .RATE(SCAN_HZ)) u_tick_scan (
        .clk_50mhz (clk_50mhz),
        .rst_      (rst_),
        .tick      (w_tick_scan)
    );

    tick_gen #(.CLK_HZ(CLK_HZ), .RATE(KEY_HZ)) u_tick_key (
        .clk_50mhz (clk_50mhz),
        .rst_      (rst_),
        .tick      (w_tick_key)
    );

    tick_gen #(.CLK_HZ(CLK_HZ), .RATE(SEC_HZ)) u_tick_sec (
        .clk_50mhz (clk_50mhz),
        .rst_      (rst_),
        .tick      (w_tick_sec)
    );

    assign tick_sec = w_tick_sec;

    // Two-flop synchronizer; reset to all-ones so keys read as released.
    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] w_key_act;

    always_ff @(posedge clk_50mhz) begin
        if (!rst_) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= key;
            r_sync2 <= r_sync1;
        end
    end

    assign w_key_act = ~r_sync2;

    // Level only changes on a unanimous history, so any bounce shorter than
    // the history depth leaves it untouched. The rise pulse is registered in
    // the same edge that sets the level.
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        logic [DEBOUNCE_DEPTH-1:0] r_hist;
        logic                      r_level;
        logic                      r_rise;

        always_ff @(posedge clk_50mhz) begin
            if (!rst_) begin
                r_hist  <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
            end else begin
                if (w_tick_key) begin
                    r_hist <= {r_hist[DEBOUNCE_DEPTH-2:0], w_key_act[g]};
                end
                if (r_hist == '1) begin
                    r_level <= 1'b1;
                end else if (r_hist == '0) begin
                    r_level <= 1'b0;
                end
                r_rise <= (r_hist == '1) && !r_level;
            end
        end

        assign key_level[g] = r_level;
        assign key_rise[g]  = r_rise;
    end

    // Display scan: bcd_data is only looked at on the scan tick.
    logic [2:0]            r_digit;
    logic [NUM_DIGITS-1:0] r_seg_cs;
    logic [7:0]            r_seg_data;
    logic [3:0]            w_nibble;

    assign w_nibble = bcd_data[{r_digit, 2'b00} +: 4];

    always_ff @(posedge clk_50mhz) begin
        if (!rst_) begin
            r_digit    <= '0;
            r_seg_cs   <= '1;
            r_seg_data <= 8'hFF;
        end else if (w_tick_scan) begin
            r_seg_cs   <= ~(NUM_DIGITS'(1) << r_digit);
            r_seg_data <= SEG_FONT[w_nibble];
            r_digit    <= (r_digit == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_digit + 3'd1;
        end
    end

    assign seg_cs   = r_seg_cs;
    assign seg_data = r_seg_data;

endmodule

// File: tb/tb_board_io_core.sv
module tb_board_io_core;

    localparam int CLK_HZ  = 1000;
    localparam int SCAN_HZ = 100;
    localparam int KEY_HZ  = 50;
    localparam int SEC_HZ  = 10;
    localparam int SCAN_N  = CLK_HZ / SCAN_HZ;
    localparam int KEY_N   = CLK_HZ / KEY_HZ;
    localparam int SEC_N   = CLK_HZ / SEC_HZ;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  key;
    logic [23:0] bcd;
    logic [7:0]  key_level;
    logic [7:0]  key_rise;
    logic        tick_sec;
    logic [7:0]  seg_data;
    logic [5:0]  seg_cs;

    always #5 clk = ~clk;

    board_io_core #(
        .CLK_HZ  (CLK_HZ),
        .SCAN_HZ (SCAN_HZ),
        .KEY_HZ  (KEY_HZ),
        .SEC_HZ  (SEC_HZ)
    ) dut (
        .clk_50mhz (clk),
        .rst_      (rst_n),
        .key       (key),
        .bcd_data  (bcd),
        .key_level (key_level),
        .key_rise  (key_rise),
        .tick_sec  (tick_sec),
        .seg_data  (seg_data),
        .seg_cs    (seg_cs)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [7:0] FONT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Model: mk = clk edges since the last reset edge. Ticks land on edges that
    // are multiples of each divisor; keys reach the debouncer two edges late.
    int         mk = 0;
    int         run = -1;
    bit         valid = 1'b0;
    bit         prev_r = 1'b1;
    logic [7:0] p1, p2;
    logic [2:0] h [8];
    logic [7:0] lvl, rise, newl;
    logic [5:0] ecs;
    logic [7:0] eseg;
    logic       esec;

    // Captured DUT observations pinned against hand-computed values at the end.
    int         first_sec = -1, second_sec = -1;
    logic [5:0] s10_cs, s60_cs, s70_cs, s700_cs, r1_s10_cs;
    logic [7:0] s10_seg, s60_seg, s70_seg, s140_seg, s150_seg;
    int         lvl0_up = -1, lvl0_dn = -1, rise0_cnt = 0, lvl1_hi = 0, rise1_cnt = 0;
    logic       lvl2_before;
    bit         snap_done = 1'b0;
    logic [5:0] snap_cs;
    logic [7:0] snap_seg, snap_lvl;

    initial begin
        logic       r;
        logic [7:0] kv;
        logic [23:0] bv;
        int d;
        forever begin
            @(posedge clk);
            r  = rst_n;
            kv = key;
            bv = bcd;
            #1;
            if (!r) begin
                if (prev_r) run++;
                prev_r = 1'b0;
                valid  = 1'b1;
                mk     = 0;
                p1 = '1; p2 = '1;
                for (int i = 0; i < 8; i++) h[i] = 3'b000;
                lvl = '0; rise = '0; ecs = 6'h3F; eseg = 8'hFF; esec = 1'b0;
                if (run == 1 && !snap_done) begin
                    snap_done = 1'b1;
                    snap_cs   = seg_cs;
                    snap_seg  = seg_data;
                    snap_lvl  = key_level;
                end
            end else if (valid) begin
                prev_r = 1'b1;
                mk++;
                newl = lvl;
                for (int i = 0; i < 8; i++) begin
                    if (h[i] == 3'b111) newl[i] = 1'b1;
                    else if (h[i] == 3'b000) newl[i] = 1'b0;
                end
                if (mk % KEY_N == 0)
                    for (int i = 0; i < 8; i++) h[i] = {h[i][1:0], ~p2[i]};
                rise = newl & ~lvl;
                lvl  = newl;
                p2 = p1;
                p1 = kv;
                if (mk % SCAN_N == 0) begin
                    d    = (mk / SCAN_N - 1) % 6;
                    ecs  = ~(6'b1 << d);
                    eseg = FONT[bv[4*d +: 4]];
                end
                esec = (mk % SEC_N == SEC_N - 1);
            end
            if (valid) begin
                chk("key_level", {24'd0, key_level}, {24'd0, lvl});
                chk("key_rise",  {24'd0, key_rise},  {24'd0, rise});
                chk("tick_sec",  {31'd0, tick_sec},  {31'd0, esec});
                chk("seg_cs",    {26'd0, seg_cs},    {26'd0, ecs});
                chk("seg_data",  {24'd0, seg_data},  {24'd0, eseg});
                if (run == 0 && r) begin
                    if (tick_sec === 1'b1) begin
                        if (first_sec < 0) first_sec = mk;
                        else if (second_sec < 0) second_sec = mk;
                    end
                    if (mk == 10)  begin s10_cs = seg_cs; s10_seg = seg_data; end
                    if (mk == 60)  begin s60_cs = seg_cs; s60_seg = seg_data; end
                    if (mk == 70)  begin s70_cs = seg_cs; s70_seg = seg_data; end
                    if (mk == 140) s140_seg = seg_data;
                    if (mk == 150) s150_seg = seg_data;
                    if (mk == 700) s700_cs = seg_cs;
                    if (mk == 705) lvl2_before = key_level[2];
                    if (lvl0_up < 0 && key_level[0] === 1'b1) lvl0_up = mk;
                    if (lvl0_up >= 0 && lvl0_dn < 0 && key_level[0] === 1'b0) lvl0_dn = mk;
                    if (key_rise[0] === 1'b1) rise0_cnt++;
                    if (key_level[1] !== 1'b0) lvl1_hi++;
                    if (key_rise[1] !== 1'b0) rise1_cnt++;
                end
                if (run == 1 && r && mk == 10) r1_s10_cs = seg_cs;
            end
        end
    end

    task automatic wait_rk(input int rr, input int t);
        int guard = 0;
        while (!(run == rr && mk == t)) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wait_timeout: run %0d edge %0d not reached, stuck at %0d", rr, t, mk);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        key   = 8'hFF;
        bcd   = 24'h012345;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        wait_rk(0, 135);
        bcd = 24'hABCDEF;
        wait_rk(0, 200);
        key[0] = 1'b0;
        wait_rk(0, 300);
        key[0] = 1'b1;
        wait_rk(0, 400);
        for (int j = 0; j < 14; j++) begin
            key[1] = ~key[1];
            repeat (15) @(negedge clk);
        end
        key[1] = 1'b1;
        wait_rk(0, 620);
        key[2] = 1'b0;
        wait_rk(0, 705);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_rk(1, 150);

        chk("first_tick_sec_edge",  first_sec,  99);
        chk("second_tick_sec_edge", second_sec, 199);
        chk("scan1_cs",   {26'd0, s10_cs},  32'h3E);
        chk("scan1_seg",  {24'd0, s10_seg}, 32'h92);
        chk("scan6_cs",   {26'd0, s60_cs},  32'h1F);
        chk("scan6_seg",  {24'd0, s60_seg}, 32'hC0);
        chk("wrap_cs",    {26'd0, s70_cs},  32'h3E);
        chk("wrap_seg",   {24'd0, s70_seg}, 32'h92);
        chk("hex_digit1", {24'd0, s140_seg}, 32'h86);
        chk("hex_digit2", {24'd0, s150_seg}, 32'hA1);
        chk("key0_press_edge",   lvl0_up, 261);
        chk("key0_release_edge", lvl0_dn, 361);
        chk("key0_rise_pulses",  rise0_cnt, 1);
        chk("key1_bounce_level", lvl1_hi, 0);
        chk("key1_bounce_rise",  rise1_cnt, 0);
        chk("digit3_before_rst", {26'd0, s700_cs}, 32'h37);
        chk("key2_before_rst",   {31'd0, lvl2_before}, 32'h1);
        chk("rst_cs",    {26'd0, snap_cs},  32'h3F);
        chk("rst_seg",   {24'd0, snap_seg}, 32'hFF);
        chk("rst_level", {24'd0, snap_lvl}, 32'h00);
        chk("restart_digit0_cs", {26'd0, r1_s10_cs}, 32'h3E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
